// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the FSM state encoding, parity modes and baud divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous write FIFO feeding the UART shift register.
// A push while full is taken only when a pop happens on the same edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a write FIFO in front.
// Frames: start, DATA_BITS LSB first, optional parity, stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(CPB);
  localparam int NW  = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [NW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic                  empty;
  logic                  bit_end;
  logic [DATA_BITS-1:0]  fifo_dout;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign busy     = (state_q != ST_IDLE);
  assign wr_ready = !full || pop;
  assign push     = wr_valid && wr_ready;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_done = 1'b0;
    tx      = 1'b1;
    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        tx = sh_q[0];
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY == PAR_NONE)
                    ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + NW'(1);
          end
        end
      end
      ST_PARITY: begin
        tx = par_q;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            tx_done = 1'b1;
            bit_d   = '0;
            // back-to-back frames skip IDLE entirely
            if (!empty) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + NW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      sh_d  = fifo_dout;
      par_d = (PARITY == PAR_ODD)
            ? ~^fifo_dout : ^fifo_dout;
    end
  end

endmodule
